qar_icache_sa: RTL
==================

Name: qar_icache_sa

Overview:
Parametrised set-associative instruction cache for qar_core. It replaces the fixed direct-mapped ICACHE_ENTRIES array with a standalone block, placed between the core fetch port and the external imem_valid/imem_ready bus. Adds multi-word lines, 1- or 2-way associativity with LRU replacement, and flush support. Uses the same valid/ready handshake style as the core's instruction and data buses.

Parameters:
ENTRIES, 8, number of sets; power of two, minimum 2
LINE_WORDS, 2, 32-bit words per line; power of two, 1 to 8
WAYS, 2, associativity; legal values 1 or 2
ADDR_WIDTH, 32, byte-address width on the CPU and memory sides

Ports:
clk  input  1  single clock, all logic on the rising edge
rst  input  1  reset, synchronous, active-high
cpu_valid  input  1  fetch request; held with a stable cpu_addr until cpu_ready
cpu_addr  input  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
cpu_ready  output  1  one-cycle pulse; cpu_rdata is valid in the same cycle
cpu_rdata  output  32  fetched instruction word
flush  input  1  single-cycle pulse that invalidates all lines
mem_valid  output  1  refill read request to the external instruction memory
mem_addr  output  ADDR_WIDTH  word-aligned refill address
mem_ready  input  1  refill word accepted; mem_rdata is valid
mem_rdata  input  32  refill data
busy  output  1  high while in the REFILL or RESPOND state

Behaviour:
- Address split: offset = log2(LINE_WORDS) bits above bit 1; index = log2(ENTRIES) bits above the offset; tag = remaining upper bits.
- Storage: data array [WAYS][ENTRIES][LINE_WORDS] x 32; tag array plus valid bit per way/set, valid bits held in flops; one LRU bit per set when WAYS=2.
- Reset: state IDLE; all valid bits 0; LRU bits 0; cpu_ready 0; cpu_rdata 0; mem_valid 0; mem_addr 0; busy 0; pending-flush flag 0.
- States: IDLE, REFILL, RESPOND.
- IDLE:
  - If flush=1, clear all valid bits at the next edge. Flush takes priority over a cpu_valid presented in the same cycle; that request is evaluated the following cycle.
  - If cpu_valid=1, cpu_ready=0 and the lookup hits: at the next edge cpu_ready=1 and cpu_rdata=hit word (one-cycle hit latency). Update LRU so the other way becomes the LRU.
  - On a miss: select the victim (first invalid way, way 0 preferred; otherwise the LRU way) and go to REFILL with word counter 0.
  - Requests are not sampled in the cycle cpu_ready is high, so sustained hit throughput is one fetch per two cycles.
- REFILL:
  - mem_valid=1; mem_addr = line base + counter*4. Words are fetched from offset 0 upward.
  - mem_addr and mem_valid stay stable until mem_ready.
  - On each mem_ready, write mem_rdata into the victim way and increment the counter. mem_ready while mem_valid=0 is ignored.
  - After LINE_WORDS transfers: drop mem_valid, write the tag, set valid, update LRU, and go to RESPOND.
- RESPOND: for one cycle, drive cpu_ready=1 and cpu_rdata = the requested word from the filled line, then return to IDLE.
- flush during REFILL or RESPOND:
  - Latch it into the pending-flush flag.
  - The refill completes and the response is delivered with correct data.
  - All valid bits, including the new line, are cleared on the transition back to IDLE.
- Reset mid-refill: the transaction is abandoned and mem_valid=0 after the reset edge. Nothing is installed.
- WAYS=1: LRU logic is absent and the victim is always way 0.

Optional Feature:
Macro QAR_ICACHE_STATS_EN.
- Defined: adds two output ports, hit_count [31:0] and miss_count [31:0].
  - hit_count increments on each IDLE hit; miss_count increments on each IDLE miss.
  - Both counters wrap at 2^32, reset to 0, and are cleared by rst only (not by flush).
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold miss: defaults, imem[i]=i+0x100, fetch 0x00.
  - Expect exactly 2 mem transactions, at 0x00 then 0x04, then a cpu_ready pulse with 0x100.
  - A following fetch of 0x04 returns 0x104 one cycle after sampling, with no mem_valid.
- Loop: fetch 0x00..0x1C sequentially 10 times (80 fetches).
  - Expect 8 mem transactions in total.
  - With QAR_ICACHE_STATS_EN: hit_count=76, miss_count=4.
- LRU conflict: fetch 0x000, 0x040, 0x000, then 0x080 (all map to set 0); 0x080 evicts the 0x040 line.
  - Refetching 0x000 hits; refetching 0x040 misses.
- Flush in IDLE: warm line 0x00, pulse flush, fetch 0x00.
  - Expect a miss with 2 mem transactions.
- Flush during REFILL: pulse flush while the first refill word is pending.
  - The response is still correct (0x100); the next fetch of 0x00 misses again.
- Reset mid-refill: assert rst while mem_valid=1.
  - mem_valid=0 and cpu_ready=0 next cycle, busy=0.
  - After release, fetch 0x00 misses.

Source files
------------

// File: rtl/qar_icache_sa_if.sv
// Fetch-side and refill-side handshake bundle for qar_icache_sa.
// The slave modport is the cache; the master modport is the core/memory side.
interface qar_icache_sa_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  cpu_valid;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic                  cpu_ready;
  logic [31:0]           cpu_rdata;
  logic                  flush;
  logic                  mem_valid;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ready;
  logic [31:0]           mem_rdata;
  logic                  busy;

  modport slave (
    input  cpu_valid, cpu_addr, flush, mem_ready, mem_rdata,
    output cpu_ready, cpu_rdata, mem_valid, mem_addr, busy
  );

  modport master (
    output cpu_valid, cpu_addr, flush, mem_ready, mem_rdata,
    input  cpu_ready, cpu_rdata, mem_valid, mem_addr, busy
  );
endinterface

// File: rtl/qar_icache_sa.sv
// Set-associative instruction cache (1 or 2 ways, LRU) with multi-word line refill and flush.
// Optional hit/miss counters when QAR_ICACHE_STATS_EN is defined.
module qar_icache_sa #(
  parameter int ENTRIES    = 8,
  parameter int LINE_WORDS = 2,
  parameter int WAYS       = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  qar_icache_sa_if.slave    bus
`ifdef QAR_ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - IDX_W;
  localparam int CW    = (OFF_W > 0) ? OFF_W : 1;

  typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_t;
  state_t state_q, state_d;

  logic [31:0]      data_q  [WAYS][ENTRIES][LINE_WORDS];
  logic [TAG_W-1:0] tag_q   [WAYS][ENTRIES];
  logic [ENTRIES-1:0] valid_q [WAYS];

  logic [ADDR_WIDTH-3:0] word_addr;
  logic [CW-1:0]         lk_off;
  logic [IDX_W-1:0]      lk_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic [ADDR_WIDTH-1:0] lk_base;

  assign word_addr = bus.cpu_addr[ADDR_WIDTH-1:2];
  assign lk_off    = CW'(word_addr) & CW'(LINE_WORDS - 1);
  assign lk_idx    = IDX_W'(word_addr >> OFF_W);
  assign lk_tag    = TAG_W'(word_addr >> (OFF_W + IDX_W));
  assign lk_base   = ADDR_WIDTH'({lk_tag, lk_idx}) << (OFF_W + 2);

  logic                  ready_q, ready_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  flush_q, flush_d;
  logic [TAG_W-1:0]      req_tag_q, req_tag_d;
  logic [IDX_W-1:0]      req_idx_q, req_idx_d;
  logic [CW-1:0]         req_off_q, req_off_d;
  logic                  way_q, way_d;

  logic hit, hit_way, victim, lru_rd;
  logic lru_we, lru_wval;
  logic [IDX_W-1:0] lru_widx;
  logic clear_valid, fill_we, install, hit_evt, miss_evt;

  if (WAYS == 2) begin : g_lru
    // Each bit names the least-recently-used way of its set.
    logic [ENTRIES-1:0] lru_q;
    always_ff @(posedge clk) begin
      if (rst) lru_q <= '0;
      else if (lru_we) lru_q[lru_widx] <= lru_wval;
    end
    assign lru_rd = lru_q[lk_idx];
  end else begin : g_no_lru
    assign lru_rd = 1'b0;
  end

  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[w][lk_idx] && tag_q[w][lk_idx] == lk_tag) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
    end
    if (!valid_q[0][lk_idx])             victim = 1'b0;
    else if (!valid_q[WAYS-1][lk_idx])   victim = 1'(WAYS - 1);
    else                                 victim = lru_rd;
  end

  always_comb begin
    state_d     = state_q;
    ready_d     = 1'b0;
    rdata_d     = rdata_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    cnt_d       = cnt_q;
    flush_d     = flush_q;
    req_tag_d   = req_tag_q;
    req_idx_d   = req_idx_q;
    req_off_d   = req_off_q;
    way_d       = way_q;
    clear_valid = 1'b0;
    fill_we     = 1'b0;
    install     = 1'b0;
    lru_we      = 1'b0;
    lru_widx    = lk_idx;
    lru_wval    = 1'b0;
    hit_evt     = 1'b0;
    miss_evt    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          clear_valid = 1'b1;
        end else if (bus.cpu_valid && !ready_q) begin
          if (hit) begin
            ready_d  = 1'b1;
            rdata_d  = data_q[hit_way][lk_idx][lk_off];
            lru_we   = 1'b1;
            lru_wval = ~hit_way;
            hit_evt  = 1'b1;
          end else begin
            miss_evt    = 1'b1;
            state_d     = REFILL;
            req_tag_d   = lk_tag;
            req_idx_d   = lk_idx;
            req_off_d   = lk_off;
            way_d       = victim;
            cnt_d       = '0;
            mem_valid_d = 1'b1;
            mem_addr_d  = lk_base;
          end
        end
      end
      REFILL: begin
        if (bus.flush) flush_d = 1'b1;
        if (mem_valid_q && bus.mem_ready) begin
          fill_we = 1'b1;
          // Capture the requested word as it streams past so RESPOND needs no array read.
          if (cnt_q == req_off_q) rdata_d = bus.mem_rdata;
          if (cnt_q == CW'(LINE_WORDS - 1)) begin
            mem_valid_d = 1'b0;
            install     = 1'b1;
            lru_we      = 1'b1;
            lru_widx    = req_idx_q;
            lru_wval    = ~way_q;
            ready_d     = 1'b1;
            state_d     = RESPOND;
          end else begin
            cnt_d      = cnt_q + 1'b1;
            mem_addr_d = mem_addr_q + ADDR_WIDTH'(4);
          end
        end
      end
      RESPOND: begin
        state_d = IDLE;
        if (bus.flush || flush_q) begin
          clear_valid = 1'b1;
          flush_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      cnt_q       <= '0;
      flush_q     <= 1'b0;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      req_off_q   <= '0;
      way_q       <= 1'b0;
      for (int unsigned w = 0; w < WAYS; w++) valid_q[w] <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      cnt_q       <= cnt_d;
      flush_q     <= flush_d;
      req_tag_q   <= req_tag_d;
      req_idx_q   <= req_idx_d;
      req_off_q   <= req_off_d;
      way_q       <= way_d;
      if (clear_valid) begin
        for (int unsigned w = 0; w < WAYS; w++) valid_q[w] <= '0;
      end else if (install) begin
        valid_q[way_q][req_idx_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we && !rst) data_q[way_q][req_idx_q][cnt_q] <= bus.mem_rdata;
    if (install && !rst) tag_q[way_q][req_idx_q] <= req_tag_q;
  end

`ifdef QAR_ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_evt)  hit_count  <= hit_count + 32'd1;
      if (miss_evt) miss_count <= miss_count + 32'd1;
    end
  end
`endif

  assign bus.cpu_ready = ready_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
